// File: rtl/io_arb_pkg.sv
// ---------------------------------------------------------------------------
// io_arb_pkg
// Shared definitions for the I/O arbiter.
//   NREQ_DEF       : default number of I/O requesters
//   WDOG_WORDS_DEF : default maximum grant length in word times
//                    (216 = two drum revolutions)
//   arb_state_e    : arbiter FSM encoding (IDLE / GRANT / RELEASE)
// ---------------------------------------------------------------------------
package io_arb_pkg;

    localparam int NREQ_DEF       = 4;
    localparam int WDOG_WORDS_DEF = 216;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/io_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. It scans req starting at index ptr
// and wraps modulo N. The first set bit found is the winner.
//   req   : in,  N      request vector
//   ptr   : in,  IDW    index that has first priority
//   valid : out, 1      at least one request is set
//   idx   : out, IDW    index of the winner (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic w_found;
    int   w_cand;

    always_comb begin
        valid   = |req;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < N; k++) begin
            // Candidate is (ptr + k) mod N. Both operands are below N,
            // so a single subtraction performs the wrap.
            w_cand = int'(ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                idx     = w_cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/io_arbiter.sv
// ---------------------------------------------------------------------------
// io_arbiter
// Round-robin arbiter for the shared I/O shift path. Arbitration happens
// only at word-time boundaries (TE). Each grant is guarded by a watchdog
// that counts word times.
//
// Handshake: a requester holds REQ[i] high while it wants the path. GNT[i]
// is the registered grant. The holder gives the path back either with a
// one-CLOCK DONE[i] pulse or by dropping REQ[i]. The grant is then cleared
// on the next CLOCK, and the path stays free for one CLOCK (RELEASE).
// Nothing is re-arbitrated until the following TE.
//
// Ports
//   CLOCK       : in,  1      system clock; all state uses the rising edge
//   rst_n       : in,  1      asynchronous active-low reset
//   TE          : in,  1      end-of-word-time strobe, one CLOCK wide
//   SW_NO_GO    : in,  1      blocks new grants while high
//   REQ         : in,  NREQ   level requests
//   DONE        : in,  NREQ   one-CLOCK release pulses
//   GNT         : out, NREQ   one-hot grant, or all zero
//   GNT_ID      : out, IDW    index of the holder (0 when idle)
//   BUSY        : out, 1      high whenever GNT is nonzero
//   TIMEOUT     : out, 1      one-CLOCK pulse when the watchdog revokes
//   o_dbg_state : out, 2      current FSM state
//   o_dbg_ptr   : out, IDW    current round-robin pointer
// ---------------------------------------------------------------------------
module io_arbiter
    import io_arb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int WDOG_WORDS = WDOG_WORDS_DEF
) (
    input  logic                    CLOCK,
    input  logic                    rst_n,
    input  logic                    TE,
    input  logic                    SW_NO_GO,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         DONE,
    output logic [NREQ-1:0]         GNT,
    output logic [$clog2(NREQ)-1:0] GNT_ID,
    output logic                    BUSY,
    output logic                    TIMEOUT,
    output logic [1:0]              o_dbg_state,
    output logic [$clog2(NREQ)-1:0] o_dbg_ptr
);

    localparam int IDW = $clog2(NREQ);
    localparam int WW  = $clog2(WDOG_WORDS + 1);

    localparam logic [IDW-1:0] LAST_IDX  = IDW'(NREQ - 1);
    localparam logic [WW-1:0]  WDOG_LAST = WW'(WDOG_WORDS - 1);
    localparam logic [WW-1:0]  WDOG_MAX  = WW'(WDOG_WORDS);

    arb_state_e      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_gnt_id;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_timeout;
    logic [WW-1:0]   r_wdog;

    logic            w_pick_valid;
    logic [IDW-1:0]  w_pick_idx;
    logic            w_arb;
    logic            w_hold_done;
    logic            w_hold_drop;
    logic            w_wdog_exp;
    logic [IDW-1:0]  w_next_ptr;

    rr_pick #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr_pick (
        .req   (REQ),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_arb       = TE && w_pick_valid && !SW_NO_GO;
    // Only the holder's DONE and REQ bits are looked at during GRANT.
    assign w_hold_done = DONE[r_gnt_id];
    assign w_hold_drop = !REQ[r_gnt_id];
    // This TE is the one that brings the count up to WDOG_WORDS.
    assign w_wdog_exp  = TE && (r_wdog == WDOG_LAST);
    assign w_next_ptr  = (r_gnt_id == LAST_IDX) ? '0 : r_gnt_id + IDW'(1);

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt_id  <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_wdog    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_state  <= GRANT;
                        r_gnt    <= NREQ'(1) << w_pick_idx;
                        r_gnt_id <= w_pick_idx;
                        r_busy   <= 1'b1;
                        r_wdog   <= '0;
                    end
                end
                GRANT: begin
                    // Release by the holder has priority over the watchdog.
                    // When both happen on the same CLOCK, TIMEOUT stays low.
                    if (w_hold_done || w_hold_drop || w_wdog_exp) begin
                        r_state   <= RELEASE;
                        r_gnt     <= '0;
                        r_gnt_id  <= '0;
                        r_busy    <= 1'b0;
                        r_ptr     <= w_next_ptr;
                        r_timeout <= !(w_hold_done || w_hold_drop);
                        if (w_wdog_exp) begin
                            r_wdog <= WDOG_MAX;
                        end
                    end else if (TE && (r_wdog != WDOG_MAX)) begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign GNT         = r_gnt;
    assign GNT_ID      = r_gnt_id;
    assign BUSY        = r_busy;
    assign TIMEOUT     = r_timeout;
    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

endmodule
